// File: rtl/sa_pkg.sv
// sa_pkg: FSM states, default geometry, flush length and requantisation helper for the OS tile.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package sa_pkg;

    localparam int SA_D_W       = 8;
    localparam int SA_ACC_W     = 24;
    localparam int SA_ROWS      = 16;
    localparam int SA_COLS      = 16;
    // Zero-operand steps needed after the last beat so that PE(SA_R-1, SA_C-1) has seen it.
    localparam int SA_FLUSH_LEN = SA_ROWS + SA_COLS - 1;

    localparam logic signed [SA_ACC_W-1:0] SA_SAT_MAX = SA_ACC_W'((2 ** (SA_D_W - 1)) - 1);
    localparam logic signed [SA_ACC_W-1:0] SA_SAT_MIN = SA_ACC_W'(-(2 ** (SA_D_W - 1)));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } sa_state_t;

    // Arithmetic right shift followed by saturation to the signed D_W range.
    function automatic logic [SA_D_W-1:0] sat_shift(input logic signed [SA_ACC_W-1:0] acc,
                                                    input logic [4:0]                  shift);
        logic signed [SA_ACC_W-1:0] t;
        t = acc >>> shift;
        if (t > SA_SAT_MAX) begin
            return SA_D_W'(SA_SAT_MAX);
        end else if (t < SA_SAT_MIN) begin
            return SA_D_W'(SA_SAT_MIN);
        end
        return t[SA_D_W-1:0];
    endfunction

endpackage

// File: rtl/sa_os_pe.sv
// sa_os_pe: one output-stationary PE; signed MAC into a local accumulator, operands forwarded right/down.
// Latency: forwarded operands and accumulator update one cycle after a step.
// Backpressure: no step means every register holds; clear zeroes only the accumulator.
module sa_os_pe #(
    parameter int D_W   = 8,
    parameter int ACC_W = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_step,
    input  logic             i_clr,
    input  logic [D_W-1:0]   i_x,
    input  logic [D_W-1:0]   i_w,
    output logic [D_W-1:0]   o_x,
    output logic [D_W-1:0]   o_w,
    output logic [ACC_W-1:0] o_acc
);

    logic [D_W-1:0]          r_x;
    logic [D_W-1:0]          r_w;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [2*D_W-1:0] w_prod;

    assign w_prod = $signed(i_x) * $signed(i_w);

    // Accumulate and forward operands on each array step; clear wins over step.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x   <= '0;
            r_w   <= '0;
            r_acc <= '0;
        end else begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_step) begin
                r_acc <= r_acc + ACC_W'(w_prod);
            end
            if (i_step) begin
                r_x <= i_x;
                r_w <= i_w;
            end
        end
    end

    assign o_x   = r_x;
    assign o_w   = r_w;
    assign o_acc = r_acc;

endmodule

// File: rtl/sa_os_tile.sv
// sa_os_tile: SA_R x SA_C output-stationary matmul tile; optional fused ReLU via `define SA_OUT_RELU_EN.
// Latency: START to first row valid = 1 + K_LEN + (SA_R+SA_C-1) + 1 cycles with no stalls.
// Backpressure: operand stalls freeze the array; I_OUT_RDY low holds the presented row and index.
module sa_os_tile import sa_pkg::*; #(
    parameter int D_W   = SA_D_W,
    parameter int SA_R  = SA_ROWS,
    parameter int SA_C  = SA_COLS,
    parameter int K_MAX = 128,
    parameter int ACC_W = SA_ACC_W
) (
    input  logic                        I_CLK,
    input  logic                        I_SYNC_RST,
    input  logic                        I_START,
    input  logic [$clog2(K_MAX+1)-1:0]  I_K_LEN,
    input  logic [4:0]                  I_SHIFT,
    input  logic                        I_IN_VLD,
    output logic                        O_IN_RDY,
    input  logic [SA_R*D_W-1:0]         I_X_COL,
    input  logic [SA_C*D_W-1:0]         I_W_ROW,
    output logic                        O_BUSY,
    output logic                        O_OUT_VLD,
    input  logic                        I_OUT_RDY,
    output logic [SA_C*D_W-1:0]         O_OUT_ROW,
    output logic [$clog2(SA_R)-1:0]     O_OUT_IDX,
    output logic                        O_DONE
);

    localparam int K_W       = $clog2(K_MAX + 1);
    localparam int IDX_W     = $clog2(SA_R);
    localparam int FLUSH_LEN = SA_R + SA_C - 1;
    localparam int F_W       = $clog2(FLUSH_LEN + 1);

    sa_state_t            r_state;
    sa_state_t            w_state_nxt;
    logic [K_W-1:0]       r_k_len;
    logic [K_W-1:0]       r_k_cnt;
    logic [4:0]           r_shift;
    logic [F_W-1:0]       r_fl_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_out_vld;
    logic                 r_done;
    logic [SA_C*D_W-1:0]  r_out_row;
    logic [SA_C*D_W-1:0]  w_row_q;
    logic [IDX_W-1:0]     w_rd_idx;
    logic                 w_beat;
    logic                 w_step;
    logic                 w_clr;
    logic                 w_last_beat;
    logic                 w_flush_end;
    logic                 w_out_hs;
    logic                 w_last_row;

    logic [D_W-1:0]   w_x   [SA_R][SA_C+1];
    logic [D_W-1:0]   w_w   [SA_R+1][SA_C];
    logic [ACC_W-1:0] w_acc [SA_R][SA_C];

    assign w_beat      = (r_state == LOAD) && I_IN_VLD;
    assign w_step      = w_beat || (r_state == FLUSH);
    assign w_clr       = (r_state == IDLE) && I_START;
    assign w_last_beat = w_beat && (r_k_cnt == r_k_len - K_W'(1));
    assign w_flush_end = (r_state == FLUSH) && (r_fl_cnt == F_W'(FLUSH_LEN - 1));
    assign w_out_hs    = r_out_vld && I_OUT_RDY;
    assign w_last_row  = w_out_hs && (r_idx == IDX_W'(SA_R - 1));

    // State register.
    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a zero-depth run skips straight to draining zero rows.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (I_START) w_state_nxt = (I_K_LEN == '0) ? DRAIN : LOAD;
            LOAD:    if (w_last_beat) w_state_nxt = FLUSH;
            FLUSH:   if (w_flush_end) w_state_nxt = DRAIN;
            DRAIN:   if (w_last_row) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign O_IN_RDY = (r_state == LOAD);
    assign O_BUSY   = (r_state != IDLE);

    // Run configuration latch plus beat and flush counters.
    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            r_k_len  <= '0;
            r_shift  <= '0;
            r_k_cnt  <= '0;
            r_fl_cnt <= '0;
        end else begin
            if (w_clr) begin
                r_k_len  <= I_K_LEN;
                r_shift  <= I_SHIFT;
                r_k_cnt  <= '0;
                r_fl_cnt <= '0;
            end
            if (w_beat) r_k_cnt <= r_k_cnt + K_W'(1);
            if (r_state == FLUSH) r_fl_cnt <= r_fl_cnt + F_W'(1);
        end
    end

    // Skew chains: row r of X is delayed r steps, column c of W is delayed c steps.
    for (genvar r = 0; r < SA_R; r++) begin : g_xsk
        logic [D_W-1:0] w_src;
        assign w_src = (r_state == LOAD) ? I_X_COL[r*D_W +: D_W] : '0;
        if (r == 0) begin : g_d0
            assign w_x[r][0] = w_src;
        end else begin : g_dn
            logic [D_W-1:0] r_sk [r];
            // Shift the X skew line on each array step.
            always_ff @(posedge I_CLK) begin
                if (I_SYNC_RST) begin
                    for (int i = 0; i < r; i++) r_sk[i] <= '0;
                end else if (w_step) begin
                    r_sk[0] <= w_src;
                    for (int i = 1; i < r; i++) r_sk[i] <= r_sk[i-1];
                end
            end
            assign w_x[r][0] = r_sk[r-1];
        end
    end

    for (genvar c = 0; c < SA_C; c++) begin : g_wsk
        logic [D_W-1:0] w_src;
        assign w_src = (r_state == LOAD) ? I_W_ROW[c*D_W +: D_W] : '0;
        if (c == 0) begin : g_d0
            assign w_w[0][c] = w_src;
        end else begin : g_dn
            logic [D_W-1:0] r_sk [c];
            // Shift the W skew line on each array step.
            always_ff @(posedge I_CLK) begin
                if (I_SYNC_RST) begin
                    for (int i = 0; i < c; i++) r_sk[i] <= '0;
                end else if (w_step) begin
                    r_sk[0] <= w_src;
                    for (int i = 1; i < c; i++) r_sk[i] <= r_sk[i-1];
                end
            end
            assign w_w[0][c] = r_sk[c-1];
        end
    end

    for (genvar r = 0; r < SA_R; r++) begin : g_row
        for (genvar c = 0; c < SA_C; c++) begin : g_col
            sa_os_pe #(.D_W(D_W), .ACC_W(ACC_W)) u_pe (
                .i_clk  (I_CLK),
                .i_rst  (I_SYNC_RST),
                .i_step (w_step),
                .i_clr  (w_clr),
                .i_x    (w_x[r][c]),
                .i_w    (w_w[r][c]),
                .o_x    (w_x[r][c+1]),
                .o_w    (w_w[r+1][c]),
                .o_acc  (w_acc[r][c])
            );
        end
    end

    // Requantise the row that the drain register will load next.
    always_comb begin
        w_row_q  = '0;
        w_rd_idx = (r_state == DRAIN) ? r_idx + IDX_W'(1) : '0;
        for (int c = 0; c < SA_C; c++) begin
            w_row_q[c*D_W +: D_W] = sat_shift(w_acc[w_rd_idx][c], r_shift);
`ifdef SA_OUT_RELU_EN
            if (w_row_q[c*D_W + D_W - 1]) w_row_q[c*D_W +: D_W] = '0;
`endif
        end
    end

    // Drain register: row 0 on entry, next row on each handshake, done pulse after the last.
    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            r_out_vld <= 1'b0;
            r_idx     <= '0;
            r_out_row <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_last_row;
            if (w_clr && (I_K_LEN == '0)) begin
                // Accumulators are only being cleared on this edge, so present zeros directly.
                r_out_vld <= 1'b1;
                r_idx     <= '0;
                r_out_row <= '0;
            end else if (w_flush_end) begin
                r_out_vld <= 1'b1;
                r_idx     <= '0;
                r_out_row <= w_row_q;
            end else if (w_out_hs) begin
                if (w_last_row) begin
                    r_out_vld <= 1'b0;
                end else begin
                    r_idx     <= r_idx + IDX_W'(1);
                    r_out_row <= w_row_q;
                end
            end
        end
    end

    assign O_OUT_VLD = r_out_vld;
    assign O_OUT_ROW = r_out_row;
    assign O_OUT_IDX = r_idx;
    assign O_DONE    = r_done;

endmodule

// File: tb/tb_sa_os_tile.sv
// tb_sa_os_tile: directed and randomized runs of sa_os_tile against a plain matrix-multiply model.
// Latency: n/a.
// Backpressure: drives operand-valid gaps and random output-ready stalls.
module tb_sa_os_tile;

    localparam int D_W   = 8;
    localparam int SA_R  = 16;
    localparam int SA_C  = 16;
    localparam int K_MAX = 128;
    localparam int ACC_W = 24;
    localparam int K_W   = $clog2(K_MAX + 1);
    localparam int IDX_W = $clog2(SA_R);

    logic                 clk = 1'b0;
    logic                 I_SYNC_RST;
    logic                 I_START;
    logic [K_W-1:0]       I_K_LEN;
    logic [4:0]           I_SHIFT;
    logic                 I_IN_VLD;
    logic                 O_IN_RDY;
    logic [SA_R*D_W-1:0]  I_X_COL;
    logic [SA_C*D_W-1:0]  I_W_ROW;
    logic                 O_BUSY;
    logic                 O_OUT_VLD;
    logic                 I_OUT_RDY;
    logic [SA_C*D_W-1:0]  O_OUT_ROW;
    logic [IDX_W-1:0]     O_OUT_IDX;
    logic                 O_DONE;

    int checks = 0;
    int errors = 0;

    int xm    [SA_R][K_MAX];
    int wm    [K_MAX][SA_C];
    int exp_o [SA_R][SA_C];

    always #5 clk = ~clk;

    sa_os_tile #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .K_MAX(K_MAX), .ACC_W(ACC_W)) dut (
        .I_CLK      (clk),
        .I_SYNC_RST (I_SYNC_RST),
        .I_START    (I_START),
        .I_K_LEN    (I_K_LEN),
        .I_SHIFT    (I_SHIFT),
        .I_IN_VLD   (I_IN_VLD),
        .O_IN_RDY   (O_IN_RDY),
        .I_X_COL    (I_X_COL),
        .I_W_ROW    (I_W_ROW),
        .O_BUSY     (O_BUSY),
        .O_OUT_VLD  (O_OUT_VLD),
        .I_OUT_RDY  (I_OUT_RDY),
        .O_OUT_ROW  (O_OUT_ROW),
        .O_OUT_IDX  (O_OUT_IDX),
        .O_DONE     (O_DONE)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [SA_C*D_W-1:0] obs,
                           input logic [SA_C*D_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Requantisation rule: floor shift, clamp to signed 8 bits, optional ReLU.
    function automatic int requant(input longint acc, input int sh);
        longint t;
        t = acc >>> sh;
        if (t > 127)  t = 127;
        if (t < -128) t = -128;
`ifdef SA_OUT_RELU_EN
        if (t < 0) t = 0;
`endif
        return int'(t);
    endfunction

    task automatic model(input int k_len, input int sh);
        longint acc;
        for (int r = 0; r < SA_R; r++) begin
            for (int c = 0; c < SA_C; c++) begin
                acc = 0;
                for (int k = 0; k < k_len; k++) acc += longint'(xm[r][k] * wm[k][c]);
                exp_o[r][c] = requant(acc, sh);
            end
        end
    endtask

    function automatic logic [SA_C*D_W-1:0] exp_row(input int r);
        logic [SA_C*D_W-1:0] v;
        logic [31:0]         e;
        v = '0;
        for (int c = 0; c < SA_C; c++) begin
            e = exp_o[r][c];
            v[c*D_W +: D_W] = e[D_W-1:0];
        end
        return v;
    endfunction

    task automatic set_pattern(input int kind);
        for (int k = 0; k < K_MAX; k++) begin
            for (int r = 0; r < SA_R; r++)
                xm[r][k] = (kind == 0) ? k : (kind == 1) ? -1 : int'($urandom_range(0, 255)) - 128;
            for (int c = 0; c < SA_C; c++)
                wm[k][c] = (kind == 0) ? c : (kind == 1) ? 2 : int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // Called at a negedge; leaves the caller at the next negedge with START dropped.
    task automatic start_run(input int k_len, input int sh);
        I_START = 1'b1;
        I_K_LEN = K_W'(k_len);
        I_SHIFT = 5'(sh);
        @(negedge clk);
        I_START = 1'b0;
        I_K_LEN = K_W'($urandom_range(0, K_MAX));
        I_SHIFT = 5'($urandom);
    endtask

    // vmode: 0 always valid, 1 valid one cycle in three, 2 random.
    task automatic load_beats(input int n, input int vmode);
        int  k = 0;
        int  guard = 0;
        logic vld;
        logic [31:0] e;
        while (k < n && guard < 5000) begin
            vld = (vmode == 0) || (vmode == 1 && (guard % 3) == 0) ||
                  (vmode == 2 && $urandom_range(0, 1) == 1);
            I_IN_VLD = vld;
            for (int r = 0; r < SA_R; r++) begin e = xm[r][k]; I_X_COL[r*D_W +: D_W] = e[D_W-1:0]; end
            for (int c = 0; c < SA_C; c++) begin e = wm[k][c]; I_W_ROW[c*D_W +: D_W] = e[D_W-1:0]; end
            if (vld && O_IN_RDY === 1'b1) k++;
            guard++;
            @(negedge clk);
        end
        I_IN_VLD = 1'b0;
        if (guard >= 5000) chk("load_timeout_beats", k, n);
    endtask

    // rmode: 0 always ready, 1 random backpressure. Ends at the negedge after the last handshake.
    task automatic drain(input string tag, input int rmode);
        int  row = 0;
        int  guard = 0;
        logic rdy;
        logic stalled = 1'b0;
        logic [SA_C*D_W-1:0] prev_row = '0;
        int  prev_idx = 0;
        while (row < SA_R && guard < 5000) begin
            rdy = (rmode == 0) || ($urandom_range(0, 2) != 0);
            I_OUT_RDY = rdy;
            chk({tag, "_done_low"}, O_DONE, 0);
            if (O_OUT_VLD === 1'b1) begin
                chk({tag, "_in_rdy_low"}, O_IN_RDY, 0);
                if (stalled) begin
                    chk_row({tag, "_hold_row"}, O_OUT_ROW, prev_row);
                    chk({tag, "_hold_idx"}, O_OUT_IDX, prev_idx);
                end
                if (rdy) begin
                    chk({tag, "_idx"}, O_OUT_IDX, row);
                    chk_row({tag, "_row"}, O_OUT_ROW, exp_row(row));
                    row++;
                    stalled = 1'b0;
                end else begin
                    stalled  = 1'b1;
                    prev_row = O_OUT_ROW;
                    prev_idx = int'(O_OUT_IDX);
                end
            end
            guard++;
            @(negedge clk);
        end
        I_OUT_RDY = 1'b0;
        if (guard >= 5000) chk({tag, "_drain_timeout_rows"}, row, SA_R);
        chk({tag, "_done_pulse"}, O_DONE, 1);
        chk({tag, "_idle_after"}, O_BUSY, 0);
        @(negedge clk);
        chk({tag, "_done_single"}, O_DONE, 0);
    endtask

    task automatic run(input string tag, input int k_len, input int sh, input int vmode, input int rmode);
        model(k_len, sh);
        start_run(k_len, sh);
        load_beats(k_len, vmode);
        drain(tag, rmode);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, O_BUSY, 0);
        chk({tag, "_in_rdy"}, O_IN_RDY, 0);
        chk({tag, "_out_vld"}, O_OUT_VLD, 0);
        chk({tag, "_done"}, O_DONE, 0);
        chk({tag, "_idx"}, O_OUT_IDX, 0);
        chk_row({tag, "_row"}, O_OUT_ROW, '0);
    endtask

    initial begin
        I_SYNC_RST = 1'b1;
        I_START    = 1'b0;
        I_K_LEN    = '0;
        I_SHIFT    = '0;
        I_IN_VLD   = 1'b0;
        I_X_COL    = '0;
        I_W_ROW    = '0;
        I_OUT_RDY  = 1'b0;
        repeat (3) @(negedge clk);
        I_SYNC_RST = 1'b0;
        check_reset_outputs("reset");

        // Ramp operands: O[r][c] = 120*c before requantisation.
        set_pattern(0);
        run("ramp_sh0", 16, 0, 0, 0);
        run("ramp_sh4", 16, 4, 0, 0);
        run("ramp_sh4_bp", 16, 4, 1, 1);

        // Negative saturation at full depth: acc = -256.
        set_pattern(1);
        run("neg_sh0", 128, 0, 0, 0);
        run("neg_sh2", 128, 2, 0, 1);

        // Zero depth: zero rows, and a START during drain must not restart the run.
        model(0, 0);
        start_run(0, 0);
        chk("k0_in_rdy", O_IN_RDY, 0);
        chk("k0_first_vld", O_OUT_VLD, 1);
        I_OUT_RDY = 1'b0;
        I_START   = 1'b1;
        I_K_LEN   = K_W'(5);
        @(negedge clk);
        I_START = 1'b0;
        chk("k0_start_ignored_idx", O_OUT_IDX, 0);
        chk("k0_start_ignored_rdy", O_IN_RDY, 0);
        drain("k0", 0);
        repeat (4) @(negedge clk);
        chk("k0_no_extra_rows", O_OUT_VLD, 0);
        chk("k0_no_restart", O_BUSY, 0);

        // Abort mid-load with reset, then a clean ramp run.
        set_pattern(0);
        model(16, 0);
        start_run(16, 0);
        load_beats(5, 0);
        I_SYNC_RST = 1'b1;
        @(negedge clk);
        I_SYNC_RST = 1'b0;
        check_reset_outputs("abort");
        run("after_abort", 16, 0, 0, 0);

        // Randomized data, depth, shift and handshaking.
        for (int i = 0; i < 4; i++) begin
            set_pattern(2);
            run("rand", int'($urandom_range(1, K_MAX)), int'($urandom_range(0, 14)), 2, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_os_tile.md
Name: sa_os_tile

Overview:
Output-stationary systolic-array matrix-multiply tile, the parametrised successor of the fixed 16x16 SA wrapper. It computes an SA_R x SA_C tile of O = X*W over a run-time-selectable reduction depth K. Operands are streamed in one K-slice per beat through a valid/ready handshake. Results are requantised to D_W bits and drained row by row under backpressure. It sits between the operand buffers and the attention/softmax datapath.

Parameters:
D_W, 8, signed operand/result width
SA_R, 16, array rows (rows of X tile / O tile)
SA_C, 16, array columns (columns of W tile / O tile)
K_MAX, 128, maximum reduction depth
ACC_W, 24, signed accumulator width; must be >= 2*D_W+$clog2(K_MAX), so accumulators never overflow

Ports:
I_CLK  in  1  clock
I_SYNC_RST  in  1  synchronous active-high reset
I_START  in  1  start pulse; sampled only in IDLE
I_K_LEN  in  $clog2(K_MAX+1)  reduction depth, latched at start
I_SHIFT  in  5  arithmetic right-shift for requantisation, latched at start
I_IN_VLD  in  1  operand beat valid
O_IN_RDY  out  1  operand beat ready
I_X_COL  in  SA_R*D_W  X[r][k] for all r, r=0 in LSBs
I_W_ROW  in  SA_C*D_W  W[k][c] for all c, c=0 in LSBs
O_BUSY  out  1  high whenever state != IDLE
O_OUT_VLD  out  1  result row valid
I_OUT_RDY  in  1  result row ready
O_OUT_ROW  out  SA_C*D_W  requantised row O[idx][c]
O_OUT_IDX  out  $clog2(SA_R)  row index of O_OUT_ROW
O_DONE  out  1  one-cycle pulse after the last row handshake

Behaviour:
- Reset: state IDLE. All accumulators, skew registers and counters are 0. O_IN_RDY, O_BUSY, O_OUT_VLD and O_DONE are 0. O_OUT_ROW and O_OUT_IDX are 0. A reset asserted in any state aborts the run and discards partial results.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE -> LOAD when I_START=1. On that edge, I_K_LEN and I_SHIFT are latched and all accumulators are cleared.
- If the latched K_LEN is 0, the FSM goes IDLE -> DRAIN and emits all-zero rows.
- I_START outside IDLE is ignored.
- LOAD: O_IN_RDY=1. Each I_IN_VLD&&O_IN_RDY beat is one array step.
- LOAD -> FLUSH on the K_LEN-th accepted beat.
- No beat means no step: the whole array, including the skew registers, holds its state.
- FLUSH: O_IN_RDY=0. The array steps every cycle with zero operands injected, for exactly SA_R+SA_C-1 cycles, then goes to DRAIN.
- Skew: X row r passes through r delay stages; W column c passes through c delay stages.
- PE(r,c): on each step, acc += $signed(x_in)*$signed(w_in). It forwards x to the right and w downward, each registered once.
- DRAIN: O_OUT_VLD=1 and rows are presented in order, idx 0..SA_R-1. The index advances on each O_OUT_VLD&&I_OUT_RDY handshake.
- While O_OUT_VLD=1 and I_OUT_RDY=0, O_OUT_ROW and O_OUT_IDX are held stable.
- The handshake on row SA_R-1 moves the FSM to IDLE. O_DONE=1 in the following cycle, coincident with IDLE.
- Requantisation per element: t = acc >>> I_SHIFT (arithmetic shift). t is then saturated to [-2^(D_W-1), 2^(D_W-1)-1].
- O_OUT_ROW is registered. The first row is valid on the first DRAIN cycle; the next row is valid the cycle after each handshake. Back-to-back rows are sustained at 1 row/cycle when I_OUT_RDY stays high.
- Latency with no stalls: START -> first O_OUT_VLD = 1 + K_LEN + (SA_R+SA_C-1) + 1 cycles.

Optional Feature:
SA_OUT_RELU_EN:
- Defined: after saturation, negative results are forced to 0 (ReLU fused into the output).
- Undefined: signed saturated results are output unchanged.
- No port difference between the two builds.

Decomposition:
- Package sa_pkg holds: the state enum (IDLE/LOAD/FLUSH/DRAIN), the localparam for the flush length, and the function sat_shift(acc, shift), which returns a D_W result.
- One sub-module, sa_os_pe: a single PE containing the operand forward registers, the MAC and the accumulator, with step and clear inputs.
- The top level generates an SA_R x SA_C grid of sa_os_pe plus the skew chains, FSM and drain mux.

Test Plan:
1. X[r][k]=k, W[k][c]=c, K_LEN=16, SHIFT=0 -> O[r][c]=120*c saturated: every row is 0, 120, then 127 for c>=2.
2. Same operands with SHIFT=4 -> O[r][c]=floor(120c/16): c=1 gives 7, c=15 gives 112 (0x70). Repeat with I_IN_VLD toggling 1-in-3 and random I_OUT_RDY backpressure -> identical rows; each row held stable while stalled; exactly one O_DONE pulse.
3. X all 0xFF (-1), W all 0x02, K_LEN=128 (acc=-256) -> SHIFT=0 gives 0x80; SHIFT=2 gives 0xC0. With SA_OUT_RELU_EN defined, both give 0x00.
4. K_LEN=0 -> no O_IN_RDY; 16 rows of zeros with idx 0..15, then O_DONE. An I_START pulse during DRAIN is ignored: no restart and no extra rows.
5. Assert I_SYNC_RST for 1 cycle mid-LOAD (after 5 beats) -> next cycle all outputs are 0 and state is IDLE. A fresh run of scenario 1 then yields correct results with no residue from the aborted run.
